// File: rtl/arb_types.sv
// Shared types and default sizes for the I/D-cache to physical-memory arbiter.
package arb_types;

   localparam int LINE_WIDTH_DEF  = 256;
   localparam int ADDR_WIDTH_DEF  = 32;
   localparam int OFFSET_BITS_DEF = 5;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SERVE_I = 3'd1,
      SERVE_D = 3'd2,
      RESP_I  = 3'd3,
      RESP_D  = 3'd4
   } arb_state_t;

   typedef enum logic {
      ARB_I = 1'b0,
      ARB_D = 1'b1
   } arb_client_t;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line misses onto one physical-memory port.
// Define ARB_RR_EN for round-robin on contested grants (default: D over I).
module cache_arbiter
   import arb_types::*;
#(
   parameter int LINE_WIDTH  = LINE_WIDTH_DEF,
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int OFFSET_BITS = OFFSET_BITS_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_pmem_read,
   input  logic [ADDR_WIDTH-1:0] i_pmem_address,
   output logic [LINE_WIDTH-1:0] i_pmem_rdata,
   output logic                  i_pmem_resp,
   input  logic                  d_pmem_read,
   input  logic                  d_pmem_write,
   input  logic [ADDR_WIDTH-1:0] d_pmem_address,
   input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
   output logic [LINE_WIDTH-1:0] d_pmem_rdata,
   output logic                  d_pmem_resp,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   input  logic [LINE_WIDTH-1:0] mem_rdata,
   input  logic                  mem_resp,
   output logic                  stall
);

   arb_state_t            state_q, state_d;
   logic                  mem_read_q, mem_read_d;
   logic                  mem_write_q, mem_write_d;
   logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
   logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d;
   logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;
   logic                  i_resp_q, i_resp_d;
   logic                  d_resp_q, d_resp_d;
   logic                  stall_q, stall_d;
`ifdef ARB_RR_EN
   arb_client_t           last_grant_q, last_grant_d;
`endif

   logic                  i_req_s;
   logic                  d_req_s;
   logic                  grant_valid_s;
   arb_client_t           grant_client_s;
   logic [ADDR_WIDTH-1:0] grant_addr_s;

   assign i_req_s = i_pmem_read;
   assign d_req_s = d_pmem_read | d_pmem_write;

   // State and request registers; reset abandons any in-flight transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_address_q <= '0;
         mem_wdata_q   <= '0;
         i_rdata_q     <= '0;
         d_rdata_q     <= '0;
         i_resp_q      <= 1'b0;
         d_resp_q      <= 1'b0;
         stall_q       <= 1'b0;
`ifdef ARB_RR_EN
         last_grant_q  <= ARB_I;
`endif
      end else begin
         state_q       <= state_d;
         mem_read_q    <= mem_read_d;
         mem_write_q   <= mem_write_d;
         mem_address_q <= mem_address_d;
         mem_wdata_q   <= mem_wdata_d;
         i_rdata_q     <= i_rdata_d;
         d_rdata_q     <= d_rdata_d;
         i_resp_q      <= i_resp_d;
         d_resp_q      <= d_resp_d;
         stall_q       <= stall_d;
`ifdef ARB_RR_EN
         last_grant_q  <= last_grant_d;
`endif
      end
   end

   // Grant selection and next-state logic.
   always_comb begin
      grant_valid_s  = 1'b0;
      grant_client_s = ARB_I;
      if (i_req_s && d_req_s) begin
         grant_valid_s = 1'b1;
`ifdef ARB_RR_EN
         grant_client_s = (last_grant_q == ARB_D) ? ARB_I : ARB_D;
`else
         grant_client_s = ARB_D;
`endif
      end else if (d_req_s) begin
         grant_valid_s  = 1'b1;
         grant_client_s = ARB_D;
      end else if (i_req_s) begin
         grant_valid_s  = 1'b1;
         grant_client_s = ARB_I;
      end else begin
         grant_valid_s  = 1'b0;
         grant_client_s = ARB_I;
      end

      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grant_valid_s) begin
               state_d = (grant_client_s == ARB_D) ? SERVE_D : SERVE_I;
            end else begin
               state_d = IDLE;
            end
         end
         SERVE_I: begin
            if (mem_resp) begin
               state_d = RESP_I;
            end else begin
               state_d = SERVE_I;
            end
         end
         SERVE_D: begin
            if (mem_resp) begin
               state_d = RESP_D;
            end else begin
               state_d = SERVE_D;
            end
         end
         RESP_I:  state_d = IDLE;
         RESP_D:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Memory-port, response and stall register updates.
   always_comb begin
      mem_read_d    = mem_read_q;
      mem_write_d   = mem_write_q;
      mem_address_d = mem_address_q;
      mem_wdata_d   = mem_wdata_q;
      i_rdata_d     = i_rdata_q;
      d_rdata_d     = d_rdata_q;
      i_resp_d      = 1'b0;
      d_resp_d      = 1'b0;
      stall_d       = (state_d != IDLE);
`ifdef ARB_RR_EN
      last_grant_d  = last_grant_q;
`endif
      grant_addr_s  = (grant_client_s == ARB_D) ? d_pmem_address : i_pmem_address;

      case (state_q)
         IDLE: begin
            if (grant_valid_s) begin
               mem_address_d = {grant_addr_s[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
`ifdef ARB_RR_EN
               last_grant_d  = grant_client_s;
`endif
               if (grant_client_s == ARB_D) begin
                  // A simultaneous read+write is taken as the writeback.
                  mem_write_d = d_pmem_write;
                  mem_read_d  = ~d_pmem_write;
                  mem_wdata_d = d_pmem_wdata;
               end else begin
                  mem_write_d = 1'b0;
                  mem_read_d  = 1'b1;
               end
            end else begin
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
            end
         end
         SERVE_I: begin
            if (mem_resp) begin
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               i_rdata_d   = mem_rdata;
               i_resp_d    = 1'b1;
            end else begin
               i_resp_d    = 1'b0;
            end
         end
         SERVE_D: begin
            if (mem_resp) begin
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               d_rdata_d   = mem_read_q ? mem_rdata : d_rdata_q;
               d_resp_d    = 1'b1;
            end else begin
               d_resp_d    = 1'b0;
            end
         end
         RESP_I: begin
            i_resp_d = 1'b0;
         end
         RESP_D: begin
            d_resp_d = 1'b0;
         end
         default: begin
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
         end
      endcase
   end

   assign mem_read     = mem_read_q;
   assign mem_write    = mem_write_q;
   assign mem_address  = mem_address_q;
   assign mem_wdata    = mem_wdata_q;
   assign i_pmem_rdata = i_rdata_q;
   assign d_pmem_rdata = d_rdata_q;
   assign i_pmem_resp  = i_resp_q;
   assign d_pmem_resp  = d_resp_q;
   assign stall        = stall_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: stimulus pushes expectations, monitors pop and compare.
module tb_cache_arbiter;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         i_pmem_read = 1'b0;
   logic [31:0]  i_pmem_address = 32'h0;
   logic [255:0] i_pmem_rdata;
   logic         i_pmem_resp;
   logic         d_pmem_read = 1'b0;
   logic         d_pmem_write = 1'b0;
   logic [31:0]  d_pmem_address = 32'h0;
   logic [255:0] d_pmem_wdata = 256'h0;
   logic [255:0] d_pmem_rdata;
   logic         d_pmem_resp;
   logic         mem_read;
   logic         mem_write;
   logic [31:0]  mem_address;
   logic [255:0] mem_wdata;
   logic [255:0] mem_rdata = 256'h0;
   logic         mem_resp = 1'b0;
   logic         stall;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic         is_d;
      logic         chk_data;
      logic [255:0] data;
   } resp_t;

   typedef struct packed {
      logic         wr;
      logic [31:0]  addr;
      logic [255:0] wdata;
   } memx_t;

   resp_t resp_q[$];
   memx_t memx_q[$];

   cache_arbiter dut (
      .clk(clk), .rst(rst),
      .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
      .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
      .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
      .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
      .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .stall(stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_resp(input logic is_d, input logic [255:0] data);
      resp_t e;
      checks++;
      if (resp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_resp: got %s response, none expected", is_d ? "D" : "I");
      end else begin
         e = resp_q.pop_front();
         if (e.is_d != is_d || (e.chk_data && e.data !== data)) begin
            failures++;
            $display("FAIL resp: got client=%0d data=%h expected client=%0d data=%h",
                     is_d, data, e.is_d, e.data);
         end
      end
   endtask

   // Response monitor
   always @(negedge clk) begin
      if (i_pmem_resp) check_resp(1'b0, i_pmem_rdata);
      if (d_pmem_resp) check_resp(1'b1, d_pmem_rdata);
   end

   // Memory-port monitor: checks each new transaction and its stability
   logic  prev_act = 1'b0;
   memx_t cur;
   always @(negedge clk) begin
      memx_t e;
      logic act;
      act = mem_read | mem_write;
      if (mem_read && mem_write) begin
         checks++;
         failures++;
         $display("FAIL mem_rw_both: got read=1 write=1 expected exactly one");
      end
      if (act && !prev_act) begin
         checks++;
         if (memx_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_mem: got addr=%h write=%0d, none expected", mem_address, mem_write);
         end else begin
            e = memx_q.pop_front();
            if (mem_write !== e.wr || mem_address !== e.addr || (e.wr && mem_wdata !== e.wdata)) begin
               failures++;
               $display("FAIL mem_req: got wr=%0d addr=%h wdata=%h expected wr=%0d addr=%h wdata=%h",
                        mem_write, mem_address, mem_wdata, e.wr, e.addr, e.wdata);
            end
         end
         cur = '{wr: mem_write, addr: mem_address, wdata: mem_wdata};
      end else if (act) begin
         checks++;
         if (mem_write !== cur.wr || mem_address !== cur.addr || mem_wdata !== cur.wdata) begin
            failures++;
            $display("FAIL mem_stable: got wr=%0d addr=%h expected wr=%0d addr=%h",
                     mem_write, mem_address, cur.wr, cur.addr);
         end
      end
      prev_act = act;
   end

   // Wait for the port to go active, optionally retarget D mid-transaction, then answer
   task automatic do_mem(input int lat, input logic [255:0] data,
                         input logic chg, input logic [31:0] new_addr);
      int n;
      n = 0;
      while (!(mem_read || mem_write) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         checks++;
         failures++;
         $display("FAIL mem_timeout: got no mem request within 20 cycles, expected one");
      end
      if (chg) d_pmem_address = new_addr;
      repeat (lat) @(negedge clk);
      mem_rdata = data;
      mem_resp  = 1'b1;
      @(negedge clk);
      mem_resp  = 1'b0;
      mem_rdata = 256'h0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_mem_read"},  256'(mem_read), 256'h0);
      chk({tag, "_mem_write"}, 256'(mem_write), 256'h0);
      chk({tag, "_mem_addr"},  256'(mem_address), 256'h0);
      chk({tag, "_mem_wdata"}, mem_wdata, 256'h0);
      chk({tag, "_i_rdata"},   i_pmem_rdata, 256'h0);
      chk({tag, "_d_rdata"},   d_pmem_rdata, 256'h0);
      chk({tag, "_resps"},     256'({i_pmem_resp, d_pmem_resp}), 256'h0);
      chk({tag, "_stall"},     256'(stall), 256'h0);
   endtask

   logic [255:0] line_a5;
   logic [255:0] line_1234;
   logic [255:0] line_k;
   logic         rr_d [4];

   initial begin
      line_a5   = {32{8'hA5}};
      line_1234 = {16{16'h1234}};

      // Reset state
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b1;
      @(negedge clk);

      // 1: I-only read, unaligned address
      i_pmem_read = 1'b1;
      i_pmem_address = 32'h0000_0064;
      memx_q.push_back('{wr: 1'b0, addr: 32'h0000_0060, wdata: 256'h0});
      resp_q.push_back('{is_d: 1'b0, chk_data: 1'b1, data: line_a5});
      @(negedge clk);
      chk("t1_stall_serve", 256'(stall), 256'h1);
      do_mem(3, line_a5, 1'b0, 32'h0);
      chk("t1_stall_resp", 256'(stall), 256'h1);
      chk("t1_mem_read_off", 256'(mem_read), 256'h0);
      i_pmem_read = 1'b0;
      repeat (2) @(negedge clk);
      chk("t1_stall_idle", 256'(stall), 256'h0);
      chk("t1_i_rdata_hold", i_pmem_rdata, line_a5);

      // 2: simultaneous I read and D write; D wins, address change mid-serve ignored
      i_pmem_read = 1'b1;
      i_pmem_address = 32'h0000_0100;
      d_pmem_write = 1'b1;
      d_pmem_address = 32'h0000_0200;
      d_pmem_wdata = line_1234;
      memx_q.push_back('{wr: 1'b1, addr: 32'h0000_0200, wdata: line_1234});
      memx_q.push_back('{wr: 1'b0, addr: 32'h0000_0100, wdata: 256'h0});
      resp_q.push_back('{is_d: 1'b1, chk_data: 1'b0, data: 256'h0});
      resp_q.push_back('{is_d: 1'b0, chk_data: 1'b1, data: {8{32'hCAFE_0001}}});
      do_mem(2, 256'h0, 1'b1, 32'h0000_0300);
      d_pmem_write = 1'b0;
      do_mem(1, {8{32'hCAFE_0001}}, 1'b0, 32'h0);
      i_pmem_read = 1'b0;
      repeat (2) @(negedge clk);

      // 3: D read+write together at 0x40 is a write
      d_pmem_read = 1'b1;
      d_pmem_write = 1'b1;
      d_pmem_address = 32'h0000_004C;
      d_pmem_wdata = {8{32'h0BAD_F00D}};
      memx_q.push_back('{wr: 1'b1, addr: 32'h0000_0040, wdata: {8{32'h0BAD_F00D}}});
      resp_q.push_back('{is_d: 1'b1, chk_data: 1'b0, data: 256'h0});
      do_mem(1, 256'h0, 1'b0, 32'h0);
      d_pmem_read = 1'b0;
      d_pmem_write = 1'b0;
      repeat (2) @(negedge clk);

      // 4: reset during SERVE_D, then a stray mem_resp
      d_pmem_read = 1'b1;
      d_pmem_address = 32'h0000_0080;
      memx_q.push_back('{wr: 1'b0, addr: 32'h0000_0080, wdata: 256'h0});
      @(negedge clk);
      chk("t4_serve_read", 256'(mem_read), 256'h1);
      @(negedge clk);
      #2;
      rst = 1'b0;
      d_pmem_read = 1'b0;
      resp_q.delete();
      #1;
      check_all_zero("t4_rst");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      mem_rdata = {8{32'hDEAD_BEEF}};
      mem_resp = 1'b1;
      @(negedge clk);
      mem_resp = 1'b0;
      mem_rdata = 256'h0;
      repeat (3) @(negedge clk);
      chk("t4_stall_after", 256'(stall), 256'h0);
      chk("t4_d_rdata_after", d_pmem_rdata, 256'h0);

      // 5: continuous contention over 4 transactions (last grant is I after reset)
`ifdef ARB_RR_EN
      rr_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      rr_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      i_pmem_read = 1'b1;
      i_pmem_address = 32'h0000_0500;
      d_pmem_read = 1'b1;
      d_pmem_address = 32'h0000_0600;
      for (int k = 0; k < 4; k++) begin
         line_k = {8{32'h1000_0000 + 32'(k)}};
         memx_q.push_back('{wr: 1'b0, addr: rr_d[k] ? 32'h0000_0600 : 32'h0000_0500, wdata: 256'h0});
         resp_q.push_back('{is_d: rr_d[k], chk_data: 1'b1, data: line_k});
      end
      for (int k = 0; k < 4; k++) begin
         line_k = {8{32'h1000_0000 + 32'(k)}};
         do_mem(2, line_k, 1'b0, 32'h0);
      end
      i_pmem_read = 1'b0;
      d_pmem_read = 1'b0;
      repeat (5) @(negedge clk);

      chk("end_resp_queue", 256'(resp_q.size()), 256'h0);
      chk("end_mem_queue", 256'(memx_q.size()), 256'h0);
      chk("end_stall", 256'(stall), 256'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000 time units, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
